// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and sizing for the shift-and-add multiplier.
package shift_add_multiplier_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter width; never below one bit so degenerate widths still elaborate.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int unsigned DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/shift_add_multiplier_datapath.sv
// Shift-and-add datapath: operand registers, accumulator and the conditional adder.
module mult_datapath
    import shift_add_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   acc_next_c
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    acc;

    // Accumulator value after the current iteration; exposed so the top can
    // capture the product on the final step without an extra cycle.
    always_comb begin
        acc_next_c = acc;
        if (mplier[0]) begin
            acc_next_c = acc + mcand;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (load) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
        end else if (step) begin
            acc    <= acc_next_c;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: fixed WIDTH-iteration shift-and-add with start/busy/done handshake.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   res,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               state;
    logic [CNT_W-1:0]     count;
    logic                 load;
    logic                 step;
    logic [2*WIDTH-1:0]   acc_next_c;

    assign load = (state == IDLE) && start;
    assign step = (state == RUN);

    mult_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .step       (step),
        .a          (a),
        .b          (b),
        .acc_next_c (acc_next_c)
    );

    // Control FSM; busy/done are flops updated alongside the state they mirror.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            res   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        count <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    count <= count + CNT_W'(1);
                    if (count == LAST_CNT) begin
                        res   <= acc_next_c;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier.
module tb_shift_add_multiplier;

    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] res;
    logic           busy;
    logic           done;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] last_res = '0;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .res   (res),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one multiply and follow it cycle by cycle to completion.
    task automatic run_mult(input logic [W-1:0] ai, input logic [W-1:0] bi,
                            input logic [2*W-1:0] exp, input string tag);
        a = ai;
        b = bi;
        start = 1'b1;
        tick();                         // edge E
        start = 1'b0;
        check({tag, " busy@E"}, 64'(busy), 64'd1);
        check({tag, " done@E"}, 64'(done), 64'd0);
        for (int i = 1; i < W; i++) begin
            if (i == 5) begin
                a = ~ai;
                b = ~bi;
            end
            tick();
            check({tag, " busy run"}, 64'(busy), 64'd1);
            check({tag, " done run"}, 64'(done), 64'd0);
            check({tag, " res hold"}, res, last_res);
        end
        tick();                         // edge E+W
        check({tag, " done@E+W"}, 64'(done), 64'd1);
        check({tag, " busy@E+W"}, 64'(busy), 64'd0);
        check({tag, " res@E+W"}, res, exp);
        tick();                         // edge E+W+1
        check({tag, " done drop"}, 64'(done), 64'd0);
        check({tag, " res after"}, res, exp);
        last_res = exp;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        #1;
        check("reset res", res, 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("idle busy", 64'(busy), 64'd0);

        run_mult(32'd3, 32'd5, 64'd15, "3x5");
        tick();
        check("3x5 res later", res, 64'd15);

        run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "max");
        run_mult(32'h0C00_4638, 32'd4, 64'h0000_0000_3001_18E0, "shl2");

        // Start held high: second request during RUN ignored, next accept at E+W+2.
        a = 32'd7;
        b = 32'd6;
        start = 1'b1;
        tick();                         // edge E
        check("hold busy@E", 64'(busy), 64'd1);
        for (int i = 1; i <= W; i++) begin
            if (i == 5) begin
                a = 32'd9;
                b = 32'd9;
            end
            tick();
            if (i < W) check("hold busy run", 64'(busy), 64'd1);
        end
        check("hold done@E+W", 64'(done), 64'd1);
        check("hold res 42", res, 64'd42);
        tick();                         // E+W+1
        check("hold idle busy", 64'(busy), 64'd0);
        check("hold idle done", 64'(done), 64'd0);
        tick();                         // E+W+2: re-accept
        start = 1'b0;
        check("hold reaccept", 64'(busy), 64'd1);
        for (int i = 1; i <= W; i++) tick();
        check("hold 2nd done", 64'(done), 64'd1);
        check("hold 2nd res 81", res, 64'd81);
        tick();
        last_res = 64'd81;

        // Reset mid-operation aborts with no done pulse.
        a = 32'd100;
        b = 32'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 10; i++) tick();
        check("abort busy pre", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort res", res, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort no done", 64'(done), 64'd0);
        end
        reset = 1'b0;
        last_res = '0;
        for (int i = 0; i < W + 4; i++) begin
            tick();
            check("post reset quiet", 64'(done | busy), 64'd0);
        end

        run_mult(32'd2, 32'd2, 64'd4, "2x2");
        run_mult(32'h1234_5678, 32'd0, 64'd0, "bzero");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
